fir_coeff_ctrl: RTL and testbench
=================================

# fir_coeff_ctrl

Coefficient and stream controller for the parallel FIR datapath. Accepts coefficients over a serial valid/ready port into a shadow bank and commits them atomically to the active bank driving the FIR `i_coeffs` array, only at a caller-marked boundary. Tracks shift-register warm-up so downstream logic knows which parallel FIR outputs carry full history. Sits between the configuration bus and the FIR datapath.

## Interface
- `NB_COEFFS`, 8, coefficient width (signed).
- `N_COEFFS`, 8, number of taps.
- `PARALLELISM`, 2, samples per clock consumed by the FIR.
- `FLUSH_CYCLES`, ceil((N_COEFFS-1)/PARALLELISM), warm-up cycles; localparam, not overridable.
- `i_clock` in 1: sole clock, rising edge.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_coeff_valid` in 1: coefficient beat valid.
- `o_coeff_ready` out 1: beat accepted when valid && ready.
- `i_coeff_data` in NB_COEFFS: signed coefficient; the first beat is tap 0.
- `i_coeff_last` in 1: marks the final beat of a set.
- `i_swap_en` in 1: boundary strobe; commit allowed only in a cycle where it is high.
- `i_in_valid` in 1: FIR input vector valid this cycle.
- `o_coeffs` out NB_COEFFS x [N_COEFFS]: active bank, signed, to the FIR.
- `o_out_valid` out 1: the current FIR output vector is valid.
- `o_swap_done` out 1: one-cycle pulse after the active bank updates.
- `o_load_err` out 1: one-cycle pulse on a malformed set.

## Operation
- Reset values: `o_coeffs` all 0, `o_out_valid` 0, `o_coeff_ready` 0, `o_swap_done` 0, `o_load_err` 0, write index 0, warm counter 0, FSM in `EMPTY`.
- FSM states:
  - `EMPTY`: no committed set; ready=1.
  - `RUN`: committed set present; ready=1.
  - `PEND`: shadow complete, waiting for `i_swap_en`; ready=0.
  - `SWAP`: one cycle; active <= shadow; ready=0.
- Transitions:
  - `EMPTY`/`RUN` -> `PEND` on an accepted beat with last=1 at index N_COEFFS-1.
  - `PEND` -> `SWAP` when `i_swap_en`=1.
  - `SWAP` -> `RUN` unconditionally.
- Load: each accepted beat writes shadow[idx], then idx increments. `i_coeff_last` at idx N_COEFFS-1 completes the set and resets idx to 0.
- Error: last=1 at idx < N_COEFFS-1, or last=0 at idx N_COEFFS-1. Raise `o_load_err` the next cycle, reset idx to 0, do not commit, stay in the current state. The active bank is untouched.
- Loading while in `RUN` never disturbs `o_coeffs`.
- Warm counter: when `i_in_valid`=0, reset to 0; otherwise increment, saturating at FLUSH_CYCLES.
- `o_out_valid` = `i_in_valid` && state != `EMPTY` && cnt == FLUSH_CYCLES. It is combinational, aligned with the combinational FIR output.
- A swap does not reset the warm counter: history samples remain valid under new taps.

## Timing
- Final beat accepted on edge E. `PEND` is entered at E.
- If `i_swap_en`=1 in the cycle after E: active bank updates on edge E+1, `o_swap_done` is high during E+1..E+2, and `o_coeff_ready` returns high at E+2.
- Minimum gap between the end of one set and the first beat of the next: 2 cycles.
- `o_coeffs` changes only on the `SWAP` edge, with all taps changing on the same edge.
- Async reset mid-load or mid-`PEND`: the partial set is discarded and the block returns to reset values immediately.

## Configuration
- `FIR_COEFF_CTRL_SYM_EN` defined: symmetric-filter mode.
  - Only ceil(N_COEFFS/2) beats form a set; the last-beat check uses that count.
  - Commit mirrors the taps: active[k] = active[N_COEFFS-1-k] = shadow[k].
- Undefined: all N_COEFFS taps are loaded independently.

## Structure
- Package `fir_ctrl_pkg`: state enum (`EMPTY`, `RUN`, `PEND`, `SWAP`), `FLUSH_CYCLES` function, coefficient typedef.
- Sub-module `fir_warmup_cnt`: the saturating counter plus `o_out_valid` gating.
- FSM and the two banks live in the top module.

## Test plan
- Reset, load taps 1..8, `i_swap_en` held high -> `o_coeffs` = {1..8} two cycles after the last beat; `o_swap_done` pulses once.
- Load 1..8 then 9..16 with `i_swap_en` low for 20 cycles -> `o_coeffs` stays {1..8} and ready stays 0; pulse `i_swap_en` -> {9..16} on the next edge.
- `i_coeff_last` on beat 5 -> `o_load_err` pulse, no swap; a following correct 8-beat load commits normally.
- Continuous `i_in_valid` after commit -> `o_out_valid` first high on the 5th valid cycle (FLUSH_CYCLES=4). Drop `i_in_valid` one cycle -> 4 more valid cycles before `o_out_valid` returns.
- Assert `i_reset` during beat 4 of a load -> all outputs 0 and state `EMPTY`; a full reload commits.
- With `FIR_COEFF_CTRL_SYM_EN`, load 4 beats {1,2,3,4} -> `o_coeffs` = {1,2,3,4,4,3,2,1}.

Source files
------------

// File: rtl/fir_ctrl_pkg.sv
// Shared types and elaboration helpers for the FIR coefficient/stream controller.
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    RUN   = 2'd1,
    PEND  = 2'd2,
    SWAP  = 2'd3
  } state_t;

  localparam int NB_COEFFS_DEF = 8;
  typedef logic signed [NB_COEFFS_DEF-1:0] coeff_t;

  // Number of clocks before every tap of a PARALLELISM-wide FIR holds real samples.
  function automatic int flush_cycles(input int n_coeffs, input int parallelism);
    return (n_coeffs - 1 + parallelism - 1) / parallelism;
  endfunction

  // Register width able to hold the values 0 .. count-1 (never less than 1 bit).
  function automatic int cnt_width(input int count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

  // Shadow slot feeding active tap k; identity unless only the first half is loaded.
  function automatic int mirror_src(input int k, input int n_coeffs, input int n_load);
    return (k < n_load) ? k : (n_coeffs - 1 - k);
  endfunction

endpackage

// File: rtl/fir_coeff_ctrl_if.sv
// Serial coefficient load port between the configuration bus and fir_coeff_ctrl.
interface fir_coeff_ctrl_if #(
  parameter int NB_COEFFS = 8
);
  // A beat transfers on a rising edge where i_coeff_valid && o_coeff_ready; the master
  // holds data/last stable while valid is high and ready only depends on controller state.
  logic                        i_coeff_valid;
  logic                        o_coeff_ready;
  logic signed [NB_COEFFS-1:0] i_coeff_data;
  logic                        i_coeff_last;

  modport master (
    output i_coeff_valid,
    output i_coeff_data,
    output i_coeff_last,
    input  o_coeff_ready
  );

  modport slave (
    input  i_coeff_valid,
    input  i_coeff_data,
    input  i_coeff_last,
    output o_coeff_ready
  );
endinterface

// File: rtl/fir_warmup_cnt.sv
// Saturating shift-register warm-up counter and FIR output-valid gating.
module fir_warmup_cnt
  import fir_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 4
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_in_valid,
  input  logic i_has_set,
  output logic o_out_valid
);

  localparam int CNT_W = cnt_width(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FLUSH_CYCLES);

  logic [CNT_W-1:0] cnt_q;

  // Any gap in the input stream breaks the history, so warm-up starts over.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else if (!i_in_valid) begin
      cnt_q <= '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_out_valid = i_in_valid && i_has_set && (cnt_q == CNT_MAX);

endmodule

// File: rtl/fir_coeff_ctrl.sv
// Coefficient shadow/active bank controller with boundary-gated atomic commit.
// FIR_COEFF_CTRL_SYM_EN: load only the first half of the taps and mirror them on commit.
module fir_coeff_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int NB_COEFFS   = 8,
  parameter int N_COEFFS    = 8,
  parameter int PARALLELISM = 2
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  fir_coeff_ctrl_if.slave             cfg,
  input  logic                        i_swap_en,
  input  logic                        i_in_valid,
  output logic signed [NB_COEFFS-1:0] o_coeffs [N_COEFFS],
  output logic                        o_out_valid,
  output logic                        o_swap_done,
  output logic                        o_load_err,
  output state_t                      o_state
);

  localparam int FLUSH_CYCLES = flush_cycles(N_COEFFS, PARALLELISM);
`ifdef FIR_COEFF_CTRL_SYM_EN
  localparam int N_LOAD = (N_COEFFS + 1) / 2;
`else
  localparam int N_LOAD = N_COEFFS;
`endif
  localparam int IDX_W = cnt_width(N_LOAD);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(N_LOAD - 1);

  state_t                      state_q;
  state_t                      state_d;
  logic                        ready_q;
  logic                        ready_d;
  logic                        err_q;
  logic [IDX_W-1:0]            idx_q;
  logic signed [NB_COEFFS-1:0] shadow_q [N_LOAD];

  logic beat_acc;
  logic at_end;
  logic set_done;
  logic set_err;
  logic commit;

  assign beat_acc = cfg.i_coeff_valid && ready_q;
  assign at_end   = (idx_q == IDX_END);
  assign set_done = beat_acc && cfg.i_coeff_last && at_end;
  assign set_err  = beat_acc && (cfg.i_coeff_last != at_end);
  assign commit   = (state_q == PEND) && i_swap_en;

  // ---------------------------------------------------------------- FSM: state register
  // ready is registered from the next state so it reads 0 while reset is held.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= EMPTY;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY, RUN: if (set_done)  state_d = PEND;
      PEND:       if (i_swap_en) state_d = SWAP;
      SWAP:                      state_d = RUN;
      default:                   state_d = EMPTY;
    endcase
  end

  // ---------------------------------------------------------------- FSM: outputs
  always_comb begin
    ready_d     = 1'b0;
    o_swap_done = 1'b0;
    case (state_d)
      EMPTY, RUN: ready_d = 1'b1;
      default:    ready_d = 1'b0;
    endcase
    if (state_q == SWAP) o_swap_done = 1'b1;
  end

  assign cfg.o_coeff_ready = ready_q;
  assign o_load_err        = err_q;
  assign o_state           = state_q;

  // ---------------------------------------------------------------- shadow bank and index
  // A malformed set just rewinds the index; the shadow contents are overwritten by the next set.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      idx_q <= '0;
      err_q <= 1'b0;
      for (int k = 0; k < N_LOAD; k++) shadow_q[k] <= '0;
    end else begin
      err_q <= set_err;
      if (beat_acc) begin
        shadow_q[idx_q] <= cfg.i_coeff_data;
        if (set_done || set_err) idx_q <= '0;
        else                     idx_q <= idx_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- active bank
  // All taps move on the commit edge only; the shadow is frozen while PEND holds ready low.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < N_COEFFS; k++) o_coeffs[k] <= '0;
    end else if (commit) begin
      for (int k = 0; k < N_COEFFS; k++) o_coeffs[k] <= shadow_q[mirror_src(k, N_COEFFS, N_LOAD)];
    end
  end

  fir_warmup_cnt #(
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) u_warmup (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_in_valid  (i_in_valid),
    .i_has_set   (state_q != EMPTY),
    .o_out_valid (o_out_valid)
  );

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Self-checking bench for fir_coeff_ctrl: commit scoreboard plus per-scenario checks.
module tb_fir_coeff_ctrl;
  import fir_ctrl_pkg::*;

  localparam int NB    = 8;
  localparam int N     = 8;
  localparam int P     = 2;
  localparam int FLUSH = (N - 1 + P - 1) / P;
`ifdef FIR_COEFF_CTRL_SYM_EN
  localparam int N_LOAD = (N + 1) / 2;
`else
  localparam int N_LOAD = N;
`endif
  localparam int W         = NB * N;
  localparam int ERR_BEATS = N_LOAD / 2 + 1;

  // ---------------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 swap_en;
  logic                 in_valid;
  logic signed [NB-1:0] coeffs [N];
  logic                 out_valid;
  logic                 swap_done;
  logic                 load_err;
  state_t               state;

  fir_coeff_ctrl_if #(.NB_COEFFS(NB)) cif ();

  fir_coeff_ctrl #(
    .NB_COEFFS   (NB),
    .N_COEFFS    (N),
    .PARALLELISM (P)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .cfg         (cif),
    .i_swap_en   (swap_en),
    .i_in_valid  (in_valid),
    .o_coeffs    (coeffs),
    .o_out_valid (out_valid),
    .o_swap_done (swap_done),
    .o_load_err  (load_err),
    .o_state     (state)
  );

  int checks   = 0;
  int failures = 0;
  int swap_cnt = 0;
  logic [W-1:0] exp_q [$];

  function automatic logic [W-1:0] pack_c();
    logic [W-1:0] v;
    for (int k = 0; k < N; k++) v[k*NB +: NB] = coeffs[k];
    return v;
  endfunction

  // Expected active bank for a set whose beat j carries base+j.
  function automatic logic [W-1:0] build_exp(input int base);
    logic [W-1:0] v;
    int src;
    for (int k = 0; k < N; k++) begin
      src = (k < N_LOAD) ? k : (N - 1 - k);
      v[k*NB +: NB] = NB'(base + src);
    end
    return v;
  endfunction

  // ---------------------------------------------------------------- scoreboard
  always @(negedge clk) begin
    if (!rst && swap_done === 1'b1) begin
      logic [W-1:0] e;
      swap_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL swap_unexpected coeffs=%h with no pending set", pack_c());
      end else begin
        e = exp_q.pop_front();
        if (pack_c() !== e) begin
          failures++;
          $display("FAIL swap_coeffs got=%h exp=%h", pack_c(), e);
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_beat(input coeff_t d, input logic last);
    int guard;
    guard = 0;
    tick();
    while (cif.o_coeff_ready !== 1'b1 && guard < 40) begin
      tick();
      guard++;
    end
    if (guard >= 40) begin
      checks++;
      failures++;
      $display("FAIL beat_ready_timeout ready=%b exp=1", cif.o_coeff_ready);
    end
    cif.i_coeff_valid = 1'b1;
    cif.i_coeff_data  = d;
    cif.i_coeff_last  = last;
    @(posedge clk);
    #1;
    cif.i_coeff_valid = 1'b0;
    cif.i_coeff_last  = 1'b0;
  endtask

  task automatic load_set(input int base, input logic push);
    if (push) exp_q.push_back(build_exp(base));
    for (int k = 0; k < N_LOAD; k++) send_beat(NB'(base + k), k == N_LOAD - 1);
  endtask

  task automatic wait_run();
    int guard;
    guard = 0;
    tick();
    while (state !== RUN && guard < 40) begin
      tick();
      guard++;
    end
    checks++;
    if (state !== RUN) begin
      failures++;
      $display("FAIL wait_run state=%0d exp=%0d", state, RUN);
    end
  endtask

  // ---------------------------------------------------------------- scenarios
  task automatic test_reset();
    rst = 1'b1;
    swap_en = 1'b0;
    in_valid = 1'b0;
    cif.i_coeff_valid = 1'b0;
    cif.i_coeff_data  = '0;
    cif.i_coeff_last  = 1'b0;
    repeat (2) tick();
    checks += 6;
    if (pack_c() !== '0)        begin failures++; $display("FAIL rst_coeffs got=%h exp=0", pack_c()); end
    if (cif.o_coeff_ready !== 0) begin failures++; $display("FAIL rst_ready got=%b exp=0", cif.o_coeff_ready); end
    if (out_valid !== 1'b0)     begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    if (swap_done !== 1'b0)     begin failures++; $display("FAIL rst_swap_done got=%b exp=0", swap_done); end
    if (load_err !== 1'b0)      begin failures++; $display("FAIL rst_load_err got=%b exp=0", load_err); end
    if (state !== EMPTY)        begin failures++; $display("FAIL rst_state got=%0d exp=%0d", state, EMPTY); end
    rst = 1'b0;
    tick();
    checks += 2;
    if (cif.o_coeff_ready !== 1'b1) begin failures++; $display("FAIL empty_ready got=%b exp=1", cif.o_coeff_ready); end
    if (state !== EMPTY)            begin failures++; $display("FAIL empty_state got=%0d exp=%0d", state, EMPTY); end
    in_valid = 1'b1;
    repeat (FLUSH + 2) tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL empty_out_valid got=%b exp=0", out_valid); end
    in_valid = 1'b0;
  endtask

  task automatic test_load_swap();
    int c0;
    c0 = swap_cnt;
    swap_en = 1'b1;
    load_set(1, 1'b1);
    tick();
    checks += 2;
    if (state !== PEND)             begin failures++; $display("FAIL ls_pend got=%0d exp=%0d", state, PEND); end
    if (cif.o_coeff_ready !== 1'b0) begin failures++; $display("FAIL ls_pend_ready got=%b exp=0", cif.o_coeff_ready); end
    tick();
    checks += 3;
    if (swap_done !== 1'b1)        begin failures++; $display("FAIL ls_swap_done got=%b exp=1", swap_done); end
    if (state !== SWAP)            begin failures++; $display("FAIL ls_swap_state got=%0d exp=%0d", state, SWAP); end
    if (pack_c() !== build_exp(1)) begin failures++; $display("FAIL ls_coeffs got=%h exp=%h", pack_c(), build_exp(1)); end
    tick();
    checks += 3;
    if (cif.o_coeff_ready !== 1'b1) begin failures++; $display("FAIL ls_ready_back got=%b exp=1", cif.o_coeff_ready); end
    if (state !== RUN)              begin failures++; $display("FAIL ls_run got=%0d exp=%0d", state, RUN); end
    if (swap_done !== 1'b0)         begin failures++; $display("FAIL ls_swap_pulse got=%b exp=0", swap_done); end
    repeat (3) tick();
    checks++;
    if (swap_cnt !== c0 + 1) begin failures++; $display("FAIL ls_swap_count got=%0d exp=%0d", swap_cnt - c0, 1); end
  endtask

  task automatic test_hold_pend();
    int c0;
    c0 = swap_cnt;
    swap_en = 1'b0;
    load_set(9, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      checks += 2;
      if (pack_c() !== build_exp(1)) begin failures++; $display("FAIL hold_coeffs cyc=%0d got=%h exp=%h", i, pack_c(), build_exp(1)); end
      if (cif.o_coeff_ready !== 1'b0) begin failures++; $display("FAIL hold_ready cyc=%0d got=%b exp=0", i, cif.o_coeff_ready); end
    end
    tick();
    swap_en = 1'b1;
    @(posedge clk);
    #1;
    swap_en = 1'b0;
    tick();
    checks += 2;
    if (pack_c() !== build_exp(9)) begin failures++; $display("FAIL hold_commit got=%h exp=%h", pack_c(), build_exp(9)); end
    if (swap_done !== 1'b1)        begin failures++; $display("FAIL hold_swap_done got=%b exp=1", swap_done); end
    wait_run();
    checks++;
    if (swap_cnt !== c0 + 1) begin failures++; $display("FAIL hold_swap_count got=%0d exp=1", swap_cnt - c0); end
  endtask

  task automatic test_load_err();
    int c0;
    c0 = swap_cnt;
    swap_en = 1'b1;
    for (int k = 0; k < ERR_BEATS; k++) send_beat(NB'(21 + k), k == ERR_BEATS - 1);
    tick();
    checks += 2;
    if (load_err !== 1'b1) begin failures++; $display("FAIL err_early_pulse got=%b exp=1", load_err); end
    if (state !== RUN)     begin failures++; $display("FAIL err_early_state got=%0d exp=%0d", state, RUN); end
    tick();
    checks++;
    if (load_err !== 1'b0) begin failures++; $display("FAIL err_pulse_len got=%b exp=0", load_err); end
    for (int k = 0; k < N_LOAD; k++) send_beat(NB'(-20 - k), 1'b0);
    tick();
    checks++;
    if (load_err !== 1'b1) begin failures++; $display("FAIL err_nolast_pulse got=%b exp=1", load_err); end
    repeat (3) tick();
    checks += 2;
    if (swap_cnt !== c0)           begin failures++; $display("FAIL err_no_swap got=%0d exp=0", swap_cnt - c0); end
    if (pack_c() !== build_exp(9)) begin failures++; $display("FAIL err_active got=%h exp=%h", pack_c(), build_exp(9)); end
    load_set(31, 1'b1);
    wait_run();
    checks += 2;
    if (pack_c() !== build_exp(31)) begin failures++; $display("FAIL err_reload got=%h exp=%h", pack_c(), build_exp(31)); end
    if (swap_cnt !== c0 + 1)        begin failures++; $display("FAIL err_reload_count got=%0d exp=1", swap_cnt - c0); end
  endtask

  task automatic test_warmup();
    in_valid = 1'b0;
    repeat (2) tick();
    for (int n = 1; n <= FLUSH + 3; n++) begin
      tick();
      in_valid = 1'b1;
      #1;
      checks++;
      if (out_valid !== (n > FLUSH)) begin failures++; $display("FAIL warm_run1 n=%0d got=%b exp=%b", n, out_valid, n > FLUSH); end
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL warm_drop got=%b exp=0", out_valid); end
    for (int n = 1; n <= FLUSH + 2; n++) begin
      tick();
      in_valid = 1'b1;
      #1;
      checks++;
      if (out_valid !== (n > FLUSH)) begin failures++; $display("FAIL warm_run2 n=%0d got=%b exp=%b", n, out_valid, n > FLUSH); end
    end
    swap_en = 1'b1;
    load_set(61, 1'b1);
    wait_run();
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL warm_after_swap got=%b exp=1", out_valid); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midload();
    swap_en = 1'b1;
    for (int k = 0; k < 3; k++) send_beat(NB'(41 + k), 1'b0);
    tick();
    cif.i_coeff_valid = 1'b1;
    cif.i_coeff_data  = NB'(44);
    cif.i_coeff_last  = 1'b0;
    rst = 1'b1;
    #1;
    checks += 4;
    if (pack_c() !== '0)            begin failures++; $display("FAIL mid_rst_coeffs got=%h exp=0", pack_c()); end
    if (state !== EMPTY)            begin failures++; $display("FAIL mid_rst_state got=%0d exp=%0d", state, EMPTY); end
    if (cif.o_coeff_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got=%b exp=0", cif.o_coeff_ready); end
    if (load_err !== 1'b0)          begin failures++; $display("FAIL mid_rst_err got=%b exp=0", load_err); end
    tick();
    cif.i_coeff_valid = 1'b0;
    rst = 1'b0;
    load_set(-100, 1'b1);
    wait_run();
    checks++;
    if (pack_c() !== build_exp(-100)) begin failures++; $display("FAIL mid_reload got=%h exp=%h", pack_c(), build_exp(-100)); end
  endtask

`ifdef FIR_COEFF_CTRL_SYM_EN
  task automatic test_sym();
    logic [W-1:0] want;
    want = {8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd3, 8'd2, 8'd1};
    swap_en = 1'b1;
    load_set(1, 1'b1);
    wait_run();
    checks++;
    if (pack_c() !== want) begin failures++; $display("FAIL sym_mirror got=%h exp=%h", pack_c(), want); end
  endtask
`endif

  // ---------------------------------------------------------------- sequence and report
  initial begin
    test_reset();
    test_load_swap();
    test_hold_pend();
    test_load_err();
    test_warmup();
    test_reset_midload();
`ifdef FIR_COEFF_CTRL_SYM_EN
    test_sym();
`endif
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
